// File: rtl/imem_pkg.sv
// Shared types and constants for the instruction memory server.
package imem_pkg;

    localparam int unsigned A_SIZE_DEF = 10;
    localparam int unsigned I_SIZE_DEF = 16;

    localparam logic [15:0] NOP_INSTR = 16'h0000;

    typedef enum logic [1:0] {
        RUN     = 2'd0,
        LOAD    = 2'd1,
        RESTART = 2'd2
    } imem_state_t;

endpackage

// File: rtl/imem_array.sv
// Program storage: synchronous write, asynchronous read, no reset on contents.
module imem_array
    import imem_pkg::*;
#(
    parameter int unsigned A_SIZE = A_SIZE_DEF,
    parameter int unsigned I_SIZE = I_SIZE_DEF
) (
    input  logic              clk,
    input  logic              we,
    input  logic [A_SIZE-1:0] waddr,
    input  logic [I_SIZE-1:0] wdata,
    input  logic [A_SIZE-1:0] raddr,
    output logic [I_SIZE-1:0] rdata
);

    localparam int unsigned DEPTH = 1 << A_SIZE;

    logic [I_SIZE-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/instr_mem_server.sv
// Fetch-side program memory with a valid/ready download port and a post-load
// redirect of fetch to the program start.
module instr_mem_server
    import imem_pkg::*;
#(
    parameter int unsigned A_SIZE = A_SIZE_DEF,
    parameter int unsigned I_SIZE = I_SIZE_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [A_SIZE-1:0] pc,
    output logic [I_SIZE-1:0] instruction,
    output logic              stall,
    output logic              load_pc_flag,
    output logic [A_SIZE-1:0] load_pc,
    input  logic              load_start,
    input  logic [A_SIZE-1:0] load_base,
    input  logic              ld_valid,
    output logic              ld_ready,
    input  logic [I_SIZE-1:0] ld_data,
    input  logic              ld_last,
    output logic [A_SIZE:0]   words_loaded
);

    localparam int unsigned DEPTH = 1 << A_SIZE;

    imem_state_t       state_q;
    imem_state_t       state_d;
    logic [A_SIZE-1:0] wptr_q;
    logic [A_SIZE-1:0] base_q;
    logic [A_SIZE:0]   count_q;
    logic [I_SIZE-1:0] rdata;
    logic              accept;

    assign accept = (state_q == LOAD) && ld_valid;

    imem_array #(
        .A_SIZE (A_SIZE),
        .I_SIZE (I_SIZE)
    ) u_array (
        .clk   (clk),
        .we    (accept),
        .waddr (wptr_q),
        .wdata (ld_data),
        .raddr (pc),
        .rdata (rdata)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= RUN;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state and state-decoded outputs; reads are masked outside RUN.
    always_comb begin
        state_d      = state_q;
        stall        = 1'b1;
        ld_ready     = 1'b0;
        load_pc_flag = 1'b0;
        instruction  = I_SIZE'(NOP_INSTR);
        case (state_q)
            RUN: begin
                stall       = 1'b0;
                instruction = rdata;
                if (load_start) begin
                    state_d = LOAD;
                end
            end
            LOAD: begin
                ld_ready = 1'b1;
                if (accept && ld_last) begin
                    state_d = RESTART;
                end
            end
            RESTART: begin
                load_pc_flag = 1'b1;
                state_d      = RUN;
            end
            default: begin
                state_d = RUN;
            end
        endcase
    end

    // Download bookkeeping; the word count saturates at full depth.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            base_q  <= '0;
            wptr_q  <= '0;
            count_q <= '0;
        end else if ((state_q == RUN) && load_start) begin
            base_q  <= load_base;
            wptr_q  <= load_base;
            count_q <= '0;
        end else if (accept) begin
            wptr_q <= wptr_q + A_SIZE'(1);
            if (count_q != (A_SIZE + 1)'(DEPTH)) begin
                count_q <= count_q + (A_SIZE + 1)'(1);
            end
        end
    end

    assign load_pc      = base_q;
    assign words_loaded = count_q;

endmodule

// File: tb/tb_instr_mem_server.sv
// Self-checking bench for instr_mem_server using an address scoreboard and a
// reference memory model.
module tb_instr_mem_server;

    logic        clk = 1'b0;
    logic        reset;
    logic [9:0]  pc;
    logic [15:0] instruction;
    logic        stall;
    logic        load_pc_flag;
    logic [9:0]  load_pc;
    logic        load_start;
    logic [9:0]  load_base;
    logic        ld_valid;
    logic        ld_ready;
    logic [15:0] ld_data;
    logic        ld_last;
    logic [10:0] words_loaded;

    int total_cnt  = 0;
    int passed_cnt = 0;

    logic [15:0] model_mem [1024];
    logic [9:0]  wptr_m;
    logic [10:0] words_m;
    logic [9:0]  sb_q [$];

    instr_mem_server dut (
        .clk          (clk),
        .reset        (reset),
        .pc           (pc),
        .instruction  (instruction),
        .stall        (stall),
        .load_pc_flag (load_pc_flag),
        .load_pc      (load_pc),
        .load_start   (load_start),
        .load_base    (load_base),
        .ld_valid     (ld_valid),
        .ld_ready     (ld_ready),
        .ld_data      (ld_data),
        .ld_last      (ld_last),
        .words_loaded (words_loaded)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic start_load(input logic [9:0] base);
        load_base  = base;
        load_start = 1'b1;
        wptr_m     = base;
        words_m    = 11'd0;
        step();
        load_start = 1'b0;
    endtask

    // Presents one word for a single cycle and records it as expected.
    task automatic send_word(input logic [15:0] d, input logic last);
        ld_valid = 1'b1;
        ld_data  = d;
        ld_last  = last;
        model_mem[wptr_m] = d;
        sb_q.push_back(wptr_m);
        wptr_m = wptr_m + 10'd1;
        if (words_m != 11'd1024) words_m = words_m + 11'd1;
        step();
        ld_valid = 1'b0;
        ld_last  = 1'b0;
    endtask

    task automatic drain_scoreboard(input string name);
        logic [9:0] a;
        while (sb_q.size() > 0) begin
            a  = sb_q.pop_front();
            pc = a;
            #1;
            total_cnt++;
            if (instruction !== model_mem[a])
                $display("FAIL %s read @%h: got %h expected %h", name, a, instruction, model_mem[a]);
            else
                passed_cnt++;
        end
    endtask

    task automatic test_reset();
        reset = 1'b0; ld_valid = 1'b1; ld_data = 16'hBEEF; ld_last = 1'b0;
        load_start = 1'b0; load_base = 10'h000; pc = 10'h000;
        step(); step(); step();
        total_cnt++;
        if (stall !== 1'b0) $display("FAIL reset_stall: got %b expected 0", stall); else passed_cnt++;
        total_cnt++;
        if (ld_ready !== 1'b0) $display("FAIL reset_ld_ready: got %b expected 0", ld_ready); else passed_cnt++;
        total_cnt++;
        if (load_pc_flag !== 1'b0) $display("FAIL reset_flag: got %b expected 0", load_pc_flag); else passed_cnt++;
        total_cnt++;
        if (load_pc !== 10'h000) $display("FAIL reset_load_pc: got %h expected 000", load_pc); else passed_cnt++;
        total_cnt++;
        if (words_loaded !== 11'd0) $display("FAIL reset_words: got %0d expected 0", words_loaded); else passed_cnt++;
        reset = 1'b1;
        step(); step();
        total_cnt++;
        if (words_loaded !== 11'd0 || stall !== 1'b0)
            $display("FAIL run_valid_dropped: words %0d stall %b expected 0 0", words_loaded, stall);
        else passed_cnt++;
        ld_valid = 1'b0;
    endtask

    task automatic test_basic_load();
        int stall_cycles = 0;
        start_load(10'h000);
        total_cnt++;
        if (ld_ready !== 1'b1 || instruction !== 16'h0000)
            $display("FAIL basic_load_entry: ready %b instr %h expected 1 0000", ld_ready, instruction);
        else passed_cnt++;
        for (int i = 0; i < 4; i++) begin
            if (stall === 1'b1) stall_cycles++;
            send_word(16'h1111 * 16'(i + 1), i == 3);
        end
        if (stall === 1'b1) stall_cycles++;
        total_cnt++;
        if (load_pc_flag !== 1'b1 || load_pc !== 10'h000 || instruction !== 16'h0000 || ld_ready !== 1'b0)
            $display("FAIL basic_restart: flag %b pc %h instr %h ready %b expected 1 000 0000 0",
                     load_pc_flag, load_pc, instruction, ld_ready);
        else passed_cnt++;
        step();
        total_cnt++;
        if (stall !== 1'b0 || load_pc_flag !== 1'b0)
            $display("FAIL basic_run: stall %b flag %b expected 0 0", stall, load_pc_flag);
        else passed_cnt++;
        total_cnt++;
        if (stall_cycles != 5) $display("FAIL basic_stall_len: got %0d expected 5", stall_cycles); else passed_cnt++;
        total_cnt++;
        if (words_loaded !== words_m) $display("FAIL basic_words: got %0d expected %0d", words_loaded, words_m); else passed_cnt++;
        drain_scoreboard("basic");
    endtask

    task automatic test_wrap();
        start_load(10'h3FE);
        send_word(16'hAA01, 1'b0);
        send_word(16'hAA02, 1'b0);
        send_word(16'hAA03, 1'b1);
        total_cnt++;
        if (load_pc_flag !== 1'b1 || load_pc !== 10'h3FE)
            $display("FAIL wrap_restart: flag %b pc %h expected 1 3fe", load_pc_flag, load_pc);
        else passed_cnt++;
        step();
        total_cnt++;
        if (words_loaded !== 11'd3) $display("FAIL wrap_words: got %0d expected 3", words_loaded); else passed_cnt++;
        drain_scoreboard("wrap");
    endtask

    task automatic test_valid_toggle();
        start_load(10'h3FF);
        send_word(16'hC001, 1'b0);
        ld_data = 16'hDEAD;
        step();
        send_word(16'hC002, 1'b1);
        ld_data = 16'hDEAD;
        step();
        total_cnt++;
        if (words_loaded !== 11'd2) $display("FAIL toggle_words: got %0d expected 2", words_loaded); else passed_cnt++;
        pc = 10'h001;
        #1;
        total_cnt++;
        if (instruction !== model_mem[1]) $display("FAIL toggle_no_dup: got %h expected %h", instruction, model_mem[1]);
        else passed_cnt++;
        drain_scoreboard("toggle");
    endtask

    task automatic test_restart_ignored();
        start_load(10'h100);
        send_word(16'h5001, 1'b0);
        load_start = 1'b1;
        load_base  = 10'h200;
        send_word(16'h5002, 1'b0);
        load_start = 1'b0;
        send_word(16'h5003, 1'b1);
        total_cnt++;
        if (load_pc !== 10'h100 || load_pc_flag !== 1'b1)
            $display("FAIL ignore_base: pc %h flag %b expected 100 1", load_pc, load_pc_flag);
        else passed_cnt++;
        step();
        total_cnt++;
        if (words_loaded !== 11'd3) $display("FAIL ignore_words: got %0d expected 3", words_loaded); else passed_cnt++;
        drain_scoreboard("ignore");
    endtask

    task automatic test_reset_mid_load();
        start_load(10'h200);
        send_word(16'h7001, 1'b0);
        send_word(16'h7002, 1'b0);
        ld_valid = 1'b1;
        ld_data  = 16'h7003;
        reset    = 1'b0;
        #1;
        total_cnt++;
        if (stall !== 1'b0 || ld_ready !== 1'b0 || words_loaded !== 11'd0 || load_pc !== 10'h000)
            $display("FAIL midreset_state: stall %b ready %b words %0d pc %h expected 0 0 0 000",
                     stall, ld_ready, words_loaded, load_pc);
        else passed_cnt++;
        step();
        ld_valid = 1'b0;
        reset    = 1'b1;
        step();
        drain_scoreboard("midreset");
    endtask

    task automatic test_saturate();
        start_load(10'h000);
        for (int i = 0; i < 1025; i++) begin
            send_word(16'h8000 ^ 16'(i), i == 1024);
        end
        step();
        total_cnt++;
        if (words_loaded !== 11'd1024) $display("FAIL sat_words: got %0d expected 1024", words_loaded); else passed_cnt++;
        drain_scoreboard("sat");
    endtask

    initial begin
        test_reset();
        test_basic_load();
        test_wrap();
        test_valid_toggle();
        test_restart_ignored();
        test_reset_mid_load();
        test_saturate();
        $display("%0d/%0d checks passed", passed_cnt, total_cnt);
        $finish;
    end

endmodule
